// File: rtl/if_id_stage_pkg.sv
// Shared pipeline definitions for the fetch / IF-ID stage: reset vector,
// NOP encoding, fetch FSM states and small address helpers.
package if_id_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

  // J-type destination: upper nibble of the delay-slot pc, 26-bit word index.
  function automatic logic [31:0] jump_target(input logic [3:0]  pc4_hi,
                                              input logic [25:0] jidx);
    return {pc4_hi, jidx, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_stage_npc_sel.sv
// Next-PC selection: sequential pc+4 or a redirect from a valid IF/ID entry
// (taken branch has priority over jump).
module npc_sel
  import if_id_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        ifid_valid,
  input  logic [3:0]  ifid_pc4_hi,
  input  logic [25:0] ifid_jidx,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  output logic        redirect,
  output logic [31:0] pc_plus4,
  output logic [31:0] redirect_pc
);

  always_comb begin
    pc_plus4 = pc + 32'd4;
    redirect = ifid_valid & (branch_taken | jump);
    if (branch_taken) begin
      redirect_pc = word_align(branch_target);
    end else begin
      redirect_pc = jump_target(ifid_pc4_hi, ifid_jidx);
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch with IF/ID pipeline register, one-entry skid buffer for
// stalls, and redirect handling that can drop an in-flight memory response.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic         run_q, run_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  ifid_entry_t  ifid_q, ifid_d;
  logic         ifid_valid_q, ifid_valid_d;
  ifid_entry_t  skid_q, skid_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  logic         redirect;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_pc;

  npc_sel u_npc_sel (
    .pc            (pc_q),
    .ifid_valid    (ifid_valid_q),
    .ifid_pc4_hi   (ifid_q.pc4[31:28]),
    .ifid_jidx     (ifid_q.instr[25:0]),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .redirect      (redirect),
    .pc_plus4      (pc_plus4),
    .redirect_pc   (redirect_pc)
  );

  // run_q keeps the request low until the first edge after reset release.
  always_comb begin
    state_d       = state_q;
    run_d         = 1'b1;
    pc_d          = pc_q;
    drop_addr_d   = drop_addr_q;
    ifid_d        = ifid_q;
    ifid_valid_d  = ifid_valid_q;
    skid_d        = skid_q;
    fetch_count_d = fetch_count_q;
    imem_req      = 1'b0;
    imem_addr     = pc_q;

    if (run_q) begin
      unique case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (redirect) begin
            pc_d         = redirect_pc;
            ifid_valid_d = 1'b0;
            if (!imem_ready) begin
              state_d     = ST_DROP;
              drop_addr_d = pc_q;
            end
          end else if (imem_ready) begin
            pc_d = pc_plus4;
            if (stall) begin
              skid_d  = '{instr: imem_rdata, pc4: pc_plus4};
              state_d = ST_HOLD;
            end else begin
              ifid_d        = '{instr: imem_rdata, pc4: pc_plus4};
              ifid_valid_d  = 1'b1;
              fetch_count_d = fetch_count_q + 32'd1;
            end
          end
        end
        // HOLD always owns a full skid entry; a redirect simply abandons it.
        ST_HOLD: begin
          if (redirect) begin
            pc_d         = redirect_pc;
            ifid_valid_d = 1'b0;
            state_d      = ST_FETCH;
          end else if (!stall) begin
            ifid_d        = skid_q;
            ifid_valid_d  = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
            state_d       = ST_FETCH;
          end
        end
        ST_DROP: begin
          imem_req  = 1'b1;
          imem_addr = drop_addr_q;
          if (imem_ready) begin
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      run_q         <= 1'b0;
      pc_q          <= word_align(RESET_PC);
      ifid_q        <= '0;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      pc_q          <= pc_d;
      ifid_q        <= ifid_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q      <= skid_d;
    drop_addr_q <= drop_addr_d;
  end

  always_comb begin
    ifid_instr  = ifid_valid_q ? ifid_q.instr : NOP_INSTR;
    ifid_pc4    = ifid_q.pc4;
    ifid_valid  = ifid_valid_q;
    opcode      = ifid_instr[31:26];
    funct       = ifid_instr[5:0];
    fetch_count = fetch_count_q;
  end

endmodule
